// File: rtl/membridge_pkg.sv
// rtl/membridge_pkg.sv - shared parameters, state type and address step for the membridge data path
package membridge_pkg;
   localparam int DW_DEF         = 64;
   localparam int AW_DEF         = 32;
   localparam int LEN_W_DEF      = 4;
   localparam int RD_CREDITS_DEF = 8;
   localparam int ADDR_INC       = DW_DEF / 8;

   typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT_RESP} state_t;

   function automatic int addr_inc(input int dw);
      return dw / 8;
   endfunction
endpackage

// File: rtl/mem_credit_counter.sv
// rtl/mem_credit_counter.sv - up/down counter saturating at MAX, reset to MAX, with zero flag
module mem_credit_counter #(
   parameter int W   = 4,
   parameter int MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic zero
);
   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !dec) begin
         if (count_q != W'(MAX)) count_d = count_q + W'(1);
      end else if (dec && !inc) begin
         if (count_q != '0) count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= W'(MAX);
      else     count_q <= count_d;
   end

   assign zero = (count_q == '0);
endmodule

// File: rtl/mem_port_engine.sv
// rtl/mem_port_engine.sv - burst engine between host write/read FIFOs and the memory request bus
module mem_port_engine
   import membridge_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int AW         = AW_DEF,
   parameter int LEN_W      = LEN_W_DEF,
   parameter int RD_CREDITS = RD_CREDITS_DEF
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             done,
   input  logic             wr_valid,
   input  logic [DW-1:0]    wr_data,
   output logic             wr_ready,
   output logic             rd_valid,
   output logic [DW-1:0]    rd_data,
   input  logic             rd_pop,
   output logic             mem_req,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [DW-1:0]    mem_rdata,
   output logic             err
);
   localparam int            CW  = $clog2(RD_CREDITS) + 1;
   localparam int            BW  = LEN_W + 1;
   localparam logic [AW-1:0] INC = AW'(addr_inc(DW));

   state_t        state_q, state_d;
   logic [BW-1:0] beats_q, beats_d, cnt_q, cnt_d, outst_q, outst_d;
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d, rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d, done_q, done_d, err_q, err_d;
   logic          credits_zero, issue, gnt, slot_free, accept, rsp_ok;

   assign gnt       = mem_req_q & mem_gnt;
   assign slot_free = !mem_req_q | mem_gnt;
   assign cmd_ready = (state_q == IDLE) & !sys_rst;
   assign accept    = cmd_valid & cmd_ready;
   assign rsp_ok    = mem_rvalid & (outst_q != '0);

   mem_credit_counter #(.W(CW), .MAX(RD_CREDITS)) u_rd_credits (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .inc  (rd_pop),
      .dec  (issue),
      .zero (credits_zero)
   );

   // cnt_q counts beats loaded (write) or requests issued (read) in the current burst
   always_comb begin
      state_d     = state_q;
      beats_d     = beats_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = 1'b0;
      wr_ready    = 1'b0;
      issue       = 1'b0;
      if (gnt) begin
         mem_addr_d = mem_addr_q + INC;
         mem_req_d  = 1'b0;
      end
      case (state_q)
         IDLE: if (accept) begin
            beats_d    = BW'(cmd_len) + BW'(1);
            mem_addr_d = cmd_addr;
            mem_we_d   = cmd_write;
            cnt_d      = '0;
            if (cmd_write) begin
               state_d = WRITE;
            end else begin
               state_d = READ;
               if (!credits_zero) begin
                  issue     = 1'b1;
                  mem_req_d = 1'b1;
                  cnt_d     = BW'(1);
               end
            end
         end
         WRITE: begin
            wr_ready = wr_valid && (cnt_q < beats_q) && slot_free;
            if (wr_ready) begin
               mem_wdata_d = wr_data;
               mem_req_d   = 1'b1;
               cnt_d       = cnt_q + BW'(1);
            end
            if (gnt && (cnt_q == beats_q)) begin
               state_d  = IDLE;
               mem_we_d = 1'b0;
               done_d   = 1'b1;
            end
         end
         READ: begin
            if ((cnt_q < beats_q) && !credits_zero && slot_free) begin
               issue     = 1'b1;
               mem_req_d = 1'b1;
               cnt_d     = cnt_q + BW'(1);
            end
            if (gnt && (cnt_q == beats_q)) state_d = WAIT_RESP;
         end
         WAIT_RESP: if (outst_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      outst_d    = outst_q;
      err_d      = err_q;
      rd_valid_d = rsp_ok;
      rd_data_d  = rd_data_q;
      if (rsp_ok) rd_data_d = mem_rdata;
      if (mem_rvalid && (outst_q == '0)) err_d = 1'b1;
      case ({gnt && !mem_we_q, rsp_ok})
         2'b10:   outst_d = outst_q + BW'(1);
         2'b01:   outst_d = outst_q - BW'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         beats_q     <= '0;
         cnt_q       <= '0;
         outst_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         cnt_q       <= cnt_d;
         outst_q     <= outst_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign done      = done_q;
   assign err       = err_q;
endmodule

// File: tb/tb_mem_port_engine.sv
// tb/tb_mem_port_engine.sv - directed self-checking bench for mem_port_engine
module tb_mem_port_engine;
   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic        done, wr_valid = 1'b0, wr_ready, rd_valid, rd_pop = 1'b0;
   logic [63:0] wr_data = '0, rd_data, mem_wdata, mem_rdata = '0;
   logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0, err;
   logic [31:0] mem_addr;

   int checks = 0;
   int failures = 0;
   int g;

   mem_port_engine dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .done       (done),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_pop     (rd_pop),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .err        (err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge sys_clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_valid", rd_valid, 0);
      sys_rst = 1'b0;
      step();
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // write burst len=3 at 0x100, constant wr_valid and grant
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h100; cmd_len = 4'd3;
      #1;
      chk("wr_cmd_ready", cmd_ready, 1);
      step();
      cmd_valid = 0; wr_valid = 1; wr_data = 64'hD0; mem_gnt = 1;
      #1;
      chk("wr_first_pop", wr_ready, 1);
      chk("wr_no_req_before_pop", mem_req, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         wr_data = 64'hD0 + 64'(i) + 64'd1;
         #1;
         chk("wr_req", mem_req, 1);
         chk("wr_we", mem_we, 1);
         chk("wr_addr", mem_addr, 64'h100 + 64'(8 * i));
         chk("wr_wdata", mem_wdata, 64'hD0 + 64'(i));
         chk("wr_pop_limit", wr_ready, (i < 3) ? 64'd1 : 64'd0);
         chk("wr_done_early", done, 0);
      end
      step();
      chk("wr_done", done, 1);
      chk("wr_req_drop", mem_req, 0);
      chk("wr_idle_ready", cmd_ready, 1);
      wr_valid = 0;
      step();
      chk("wr_done_pulse", done, 0);

      // read len=15, no rd_pop: credits limit to 8 requests
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h200; cmd_len = 4'hF; mem_gnt = 1;
      step();
      cmd_valid = 0;
      g = 0;
      for (int i = 0; i < 16; i++) begin
         if (mem_req) g++;
         step();
      end
      chk("rd_credit_limit", 64'(g), 8);
      chk("rd_stalled", mem_req, 0);
      chk("rd_addr_after8", mem_addr, 64'h240);
      for (int i = 0; i < 12; i++) begin
         rd_pop = (i == 0 || i == 2 || i == 4);
         if (mem_req) g++;
         step();
      end
      rd_pop = 0;
      chk("rd_credit_return", 64'(g), 11);
      chk("rd_addr_after11", mem_addr, 64'h258);

      // reset mid-burst
      sys_rst = 1;
      #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
      chk("mid_rst_we", mem_we, 0);
      step();
      sys_rst = 0;
      #1;
      chk("mid_rst_release_ready", cmd_ready, 1);

      // stray response in IDLE sets sticky err
      mem_rvalid = 1; mem_rdata = 64'h1234;
      step();
      mem_rvalid = 0;
      chk("stray_err", err, 1);
      chk("stray_no_rd_valid", rd_valid, 0);
      step();
      chk("stray_err_sticky", err, 1);

      // credits restored to 8 after reset
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h500; cmd_len = 4'hF; mem_gnt = 1;
      step();
      cmd_valid = 0;
      g = 0;
      for (int i = 0; i < 16; i++) begin
         if (mem_req) g++;
         step();
      end
      chk("rst_credits_full", 64'(g), 8);
      sys_rst = 1;
      #1;
      chk("rst_clears_err", err, 0);
      step();
      sys_rst = 0;
      #1;

      // read len=0 at top of address space with delayed grant
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'hFFFF_FFF8; cmd_len = 4'd0; mem_gnt = 0;
      step();
      cmd_valid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_req", mem_req, 1);
         chk("hold_addr", mem_addr, 64'hFFFF_FFF8);
         step();
      end
      mem_gnt = 1;
      step();
      mem_gnt = 0;
      chk("wrap_req_drop", mem_req, 0);
      chk("wrap_addr", mem_addr, 0);
      mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF;
      step();
      mem_rvalid = 0;
      chk("resp_valid", rd_valid, 1);
      chk("resp_data", rd_data, 64'hDEAD_BEEF);
      chk("resp_done_early", done, 0);
      step();
      chk("rd_done", done, 1);
      chk("rd_valid_pulse", rd_valid, 0);
      chk("rd_no_err", err, 0);
      step();
      chk("rd_done_pulse", done, 0);

      // write with wr_valid gapped every other cycle
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h400; cmd_len = 4'd2; mem_gnt = 1;
      step();
      cmd_valid = 0;
      for (int c = 0; c < 5; c++) begin
         wr_valid = (c % 2 == 0);
         wr_data = 64'hE0 + 64'(c / 2);
         #1;
         chk("gap_wr_ready", wr_ready, (c % 2 == 0) ? 64'd1 : 64'd0);
         step();
         chk("gap_req", mem_req, (c % 2 == 0) ? 64'd1 : 64'd0);
         if (c % 2 == 0) begin
            chk("gap_wdata", mem_wdata, 64'hE0 + 64'(c / 2));
            chk("gap_addr", mem_addr, 64'h400 + 64'(8 * (c / 2)));
         end
      end
      wr_valid = 0;
      step();
      chk("gap_done", done, 1);
      chk("gap_req_drop", mem_req, 0);
      mem_gnt = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_engine.md
# mem_port_engine

Memory-side engine of the membridge data path. Accepts burst commands, drains write beats from the host-side write FIFO onto the memory bus, and returns read responses toward the host-side read FIFO. Read flow is credit-limited so responses never overrun the read FIFO. It is the consumer of the write FIFO and the producer of the read FIFO.

## Interface
Parameters:
- DW, 64, data width in bits (multiple of 8)
- AW, 32, byte address width
- LEN_W, 4, burst length field width; beats = cmd_len + 1 (1..16)
- RD_CREDITS, 8, read FIFO depth; initial and maximum credit count

Ports:
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start byte address
- cmd_len  in  LEN_W  beats minus one
- done  out  1  one-cycle pulse at burst completion
- wr_valid  in  1  write FIFO non-empty
- wr_data  in  DW  write FIFO head
- wr_ready  out  1  pop write FIFO this cycle
- rd_valid  out  1  push read FIFO this cycle
- rd_data  out  DW  read beat
- rd_pop  in  1  host consumed one read FIFO entry (returns one credit)
- mem_req  out  1  memory request
- mem_we  out  1  request is a write
- mem_addr  out  AW  request byte address
- mem_wdata  out  DW  write data
- mem_gnt  in  1  request accepted this cycle (only meaningful with mem_req)
- mem_rvalid  in  1  read response beat, in order, ≥1 cycle after gnt
- mem_rdata  in  DW  read response data
- err  out  1  sticky: response received with nothing outstanding

## Operation
- States: IDLE, WRITE, READ, WAIT_RESP.
- IDLE: cmd_ready=1. On accept, latch addr, beats=len+1, direction; go WRITE or READ. cmd_ready=0 in all other states.
- Requests: mem_req, mem_we, mem_addr, mem_wdata registered; once mem_req=1 they hold stable until mem_gnt. Each gnt advances mem_addr by DW/8, wrapping modulo 2^AW.
- WRITE: wr_ready = wr_valid & beats_loaded<beats & (!mem_req | mem_gnt). Popped beat loads mem_wdata and asserts mem_req next cycle; back-to-back beats give one gnt per cycle. Gnt of last beat -> IDLE, done pulses the following cycle.
- READ: issue request while issued<beats and credits>0; credit consumed at issue (mem_req rising edge/reload). Gnt of last request -> WAIT_RESP.
- WAIT_RESP: leave to IDLE, with done, when outstanding=0 (last response registered).
- Outstanding counter (width LEN_W+1): +1 per read gnt, −1 per mem_rvalid; same-cycle both = unchanged.
- Credits (width log2(RD_CREDITS)+1): −1 per read issue, +1 per rd_pop, same-cycle both = unchanged; saturate at RD_CREDITS (extra rd_pop ignored).
- mem_rvalid with outstanding=0: ignored, err set until reset.

## Timing
- Reset values: cmd_ready=0 during reset, 1 first cycle after; done, wr_ready, rd_valid, mem_req, mem_we, err = 0; mem_addr, mem_wdata, rd_data = 0; credits=RD_CREDITS; state IDLE.
- cmd accept to first mem_req: 1 cycle (read) or 1 cycle after first wr_ready (write).
- mem_rvalid to rd_valid/rd_data: 1 cycle, no backpressure.
- done: 1 cycle after last gnt (write) or after last rd_valid asserts (read).
- Reset mid-burst: abort immediately, counters cleared, in-flight responses after reset count as err.

## Structure
- Package membridge_pkg: DW, AW, LEN_W defaults, state enum, address-increment constant DW/8.
- Sub-module mem_credit_counter (up/down saturating counter with zero flag), instanced for read credits.

## Test plan
- Write len=3 addr 0x100, wr_valid constant, mem_gnt=1 -> 4 pops, mem_addr 0x100/108/110/118, done 1 cycle after 4th gnt.
- Read len=15, mem_gnt=1, no rd_pop -> exactly 8 requests then stall; 3 rd_pop pulses -> 3 more requests.
- Read len=0 addr 0xFFFFFFF8 with gnt delayed 5 cycles -> mem_req/addr stable 5 cycles; response data 0xDEADBEEF appears on rd_data one cycle after mem_rvalid; next addr wraps to 0.
- Write with wr_valid gapped every other cycle -> no mem_req without loaded data, data order preserved.
- mem_rvalid pulse in IDLE -> err=1, rd_valid stays 0; sys_rst clears err.
- Assert sys_rst mid read burst -> all outputs reset values same cycle, credits=8, next command completes normally.
